// File: rtl/branch_redirect_ctrl.sv
// Branch/jump resolution in EX with a static not-taken policy, plus branch statistics.
// Latency: a taken branch seen at cycle N raises redir_valid at N+1; the block is IDLE again at N+2+FLUSH_CYCLES.
// Backpressure: redir_ready low holds REDIRECT indefinitely with all outputs stable; EX inputs are ignored while busy.
//
// Ports:
//   clk, rst_n                      clock; synchronous active-low reset
//   ex_valid/ex_branch/ex_jump      EX instruction qualifiers
//   ex_funct3, ex_rs1/rs2_data      branch condition inputs
//   ex_target                       computed target PC
//   redir_valid/redir_pc/ready      redirect handshake to fetch
//   flush_if, flush_id              kill the younger pipeline registers
//   busy                            state != IDLE
//   misalign_exc                    one-cycle pulse for a taken, misaligned target
//   br_count, br_taken_count        saturating conditional-branch statistics

module branch_unit (
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        branch_taken
);
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data <  rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end
endmodule

module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_rs1_data,
  input  logic [31:0]      ex_rs2_data,
  input  logic [31:0]      ex_target,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_redir_valid, r_flush_if, r_flush_id, r_misalign;
  logic [31:0]      r_redir_pc;
  logic [CNT_W-1:0] r_br_count, r_br_taken_count;

  logic w_br_taken, w_res, w_taken, w_aligned, w_cond_br;

  branch_unit u_branch_unit (
    .funct3       (ex_funct3),
    .rs1_data     (ex_rs1_data),
    .rs2_data     (ex_rs2_data),
    .branch_taken (w_br_taken)
  );

  // EX is only resolved in IDLE; anything arriving while busy is a flushed slot.
  assign w_res     = ex_valid & (ex_branch | ex_jump) & (r_state == S_IDLE);
  assign w_taken   = ex_jump | (ex_branch & w_br_taken);
  assign w_aligned = (ex_target[1:0] == 2'b00);
  // A jump that is also flagged as a branch is treated purely as a jump.
  assign w_cond_br = w_res & ex_branch & ~ex_jump;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_res && w_taken && w_aligned) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (r_redir_valid && redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = FLUSH_INIT;
          end
        end
      end
      S_FLUSH: begin
        // cnt holds the number of FLUSH cycles still to spend, including this one.
        if (r_cnt <= 4'd1) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_redir_valid    <= 1'b0;
      r_redir_pc       <= '0;
      r_flush_if       <= 1'b0;
      r_flush_id       <= 1'b0;
      r_misalign       <= 1'b0;
      r_br_count       <= '0;
      r_br_taken_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      // Outputs are registered from the next state so they line up with r_state.
      r_redir_valid <= (w_state_nxt == S_REDIRECT);
      r_flush_id    <= (w_state_nxt == S_REDIRECT);
      r_flush_if    <= (w_state_nxt != S_IDLE);
      r_misalign    <= w_res & w_taken & ~w_aligned;
      if (r_state == S_IDLE && w_state_nxt == S_REDIRECT) r_redir_pc <= ex_target;
      if (w_cond_br && r_br_count != CNT_MAX) r_br_count <= r_br_count + 1'b1;
      if (w_cond_br && w_br_taken && r_br_taken_count != CNT_MAX)
        r_br_taken_count <= r_br_taken_count + 1'b1;
    end
  end

  assign redir_valid    = r_redir_valid;
  assign redir_pc       = r_redir_pc;
  assign flush_if       = r_flush_if;
  assign flush_id       = r_flush_id;
  assign misalign_exc   = r_misalign;
  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
  assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: scoreboard of expected redirect PCs popped at each accepted handshake.
// Latency: outputs checked 1 time unit after the edge that produced them.
// Backpressure: redir_ready is driven by the scenario tasks.

module tb_branch_redirect_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0;
  logic [2:0]    ex_funct3 = '0;
  logic [31:0]   ex_rs1_data = '0, ex_rs2_data = '0, ex_target = '0;
  logic          redir_valid, redir_ready = 1'b0;
  logic [31:0]   redir_pc;
  logic          flush_if, flush_id, busy, misalign_exc;
  logic [CW-1:0] br_count, br_taken_count;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];
  logic [CW-1:0] exp_br = '0, exp_tk = '0;

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_target(ex_target), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .flush_if(flush_if), .flush_id(flush_id), .busy(busy),
    .misalign_exc(misalign_exc), .br_count(br_count), .br_taken_count(br_taken_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one EX instruction for a single cycle; the DUT must be IDLE.
  task automatic drive(input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
    logic tk;
    tk = jp | (br & cond(f3, a, b));
    if (br && !jp) begin
      if (exp_br != '1) exp_br++;
      if (tk && exp_tk != '1) exp_tk++;
    end
    if (tk && tgt[1:0] == 2'b00) exp_q.push_back(tgt);
    ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_funct3 = f3;
    ex_rs1_data = a; ex_rs2_data = b; ex_target = tgt;
    tick();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (br_count !== exp_br || br_taken_count !== exp_tk) begin
      errors++;
      $display("FAIL %s counters br=%0d tk=%0d required br=%0d tk=%0d",
               name, br_count, br_taken_count, exp_br, exp_tk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({redir_valid, flush_if, flush_id, busy, misalign_exc} !== 5'b0 || redir_pc !== 32'h0 ||
        br_count !== '0 || br_taken_count !== '0) begin
      errors++;
      $display("FAIL reset outs v/fi/fd/b/m=%b pc=%h br=%0d tk=%0d required all 0",
               {redir_valid, flush_if, flush_id, busy, misalign_exc}, redir_pc, br_count, br_taken_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq();
    redir_ready = 1'b1;
    drive(1, 0, 3'd0, 32'd5, 32'd5, 32'h100);
    checks++;
    if ({redir_valid, flush_if, flush_id, busy} !== 4'b1111 || redir_pc !== 32'h100) begin
      errors++;
      $display("FAIL beq_redirect v/fi/fd/b=%b pc=%h required 1111 pc=00000100",
               {redir_valid, flush_if, flush_id, busy}, redir_pc);
    end
    tick();
    checks++;
    if ({redir_valid, flush_if, flush_id, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL beq_flush v/fi/fd/b=%b required 0101", {redir_valid, flush_if, flush_id, busy});
    end
    wait_idle("beq");
    check_cnt("beq");
  endtask

  task automatic test_signed_unsigned();
    redir_ready = 1'b1;
    drive(1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200);
    wait_idle("blt");
    drive(1, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300);
    checks++;
    if (redir_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bltu_not_taken v=%b busy=%b required 0 0", redir_valid, busy);
    end
    check_cnt("blt_bltu");
  endtask

  task automatic test_jal_stall();
    redir_ready = 1'b0;
    drive(0, 1, 3'd0, 32'd0, 32'd0, 32'h204);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h204 || flush_if !== 1'b1 || flush_id !== 1'b1) begin
        errors++;
        $display("FAIL jal_hold[%0d] v=%b pc=%h fi=%b fd=%b required 1 00000204 1 1",
                 i, redir_valid, redir_pc, flush_if, flush_id);
      end
      if (i < 4) begin
        // A taken-looking BEQ in the window must be ignored entirely.
        ex_valid = (i % 2 == 0); ex_branch = 1'b1; ex_funct3 = 3'd0;
        ex_rs1_data = 32'd7; ex_rs2_data = 32'd7; ex_target = 32'h400;
        tick();
        ex_valid = 1'b0; ex_branch = 1'b0;
      end
    end
    redir_ready = 1'b1;
    tick();
    checks++;
    if ({redir_valid, flush_if, flush_id, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL jal_accept v/fi/fd/b=%b required 0101", {redir_valid, flush_if, flush_id, busy});
    end
    wait_idle("jal");
    check_cnt("jal_ignored");
  endtask

  task automatic test_flush_len();
    redir_ready = 1'b1;
    drive(1, 0, 3'd5, 32'd5, 32'd5, 32'h40);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flush_if !== 1'b1 || busy !== 1'b1 || redir_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_len[%0d] fi=%b busy=%b v=%b required 1 1 0", i, flush_if, busy, redir_valid);
      end
      tick();
    end
    checks++;
    if (flush_if !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_end fi=%b busy=%b required 0 0", flush_if, busy);
    end
  endtask

  task automatic test_misalign();
    redir_ready = 1'b1;
    drive(1, 0, 3'd1, 32'd1, 32'd2, 32'h102);
    checks++;
    if (misalign_exc !== 1'b1 || redir_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse m=%b v=%b busy=%b required 1 0 0", misalign_exc, redir_valid, busy);
    end
    tick();
    checks++;
    if (misalign_exc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear m=%b busy=%b required 0 0", misalign_exc, busy);
    end
    check_cnt("misalign");
  endtask

  task automatic test_saturate();
    redir_ready = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 0, 3'd0, 32'd1, 32'd2, 32'h500);
    check_cnt("sat_br");
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 3'd7, 32'd9, 32'd3, 32'h600 + 32'(i * 4));
      wait_idle("sat_taken");
    end
    checks++;
    if (br_count !== '1 || br_taken_count !== '1) begin
      errors++;
      $display("FAIL saturate br=%0d tk=%0d required all-ones", br_count, br_taken_count);
    end
  endtask

  task automatic test_reset_mid();
    redir_ready = 1'b0;
    drive(0, 1, 3'd0, 32'd0, 32'd0, 32'h80);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    exp_br = '0;
    exp_tk = '0;
    checks++;
    if ({redir_valid, flush_if, flush_id, busy, misalign_exc} !== 5'b0 || redir_pc !== 32'h0 ||
        br_count !== '0 || br_taken_count !== '0) begin
      errors++;
      $display("FAIL reset_mid v/fi/fd/b/m=%b pc=%h br=%0d tk=%0d required all 0",
               {redir_valid, flush_if, flush_id, busy, misalign_exc}, redir_pc, br_count, br_taken_count);
    end
    rst_n = 1'b1;
    redir_ready = 1'b1;
    tick();
    drive(1, 0, 3'd0, 32'd3, 32'd3, 32'h90);
    wait_idle("after_reset");
    check_cnt("after_reset");
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && redir_valid && redir_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected redirect pc=%h required none", redir_pc);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (redir_pc !== e) begin
              errors++;
              $display("FAIL sb_pc got=%h required %h", redir_pc, e);
            end
          end
        end
      end
    join_none

    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jal_stall();
    test_flush_len();
    test_misalign();
    test_saturate();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
